ps2_scan_ctrl: RTL and testbench

Sequencer between the ps2_keyboard receive FIFO and the downstream display/ASCII logic. It pops bytes with the FIFO's nextdata_n handshake and parses E0/F0 prefixes into make/break key events. It tracks the current held key, shift state and a press counter, and presents each event on a valid/ready output port with backpressure into the FIFO.

---
 rtl/ps2_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ps2_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: pops scan-code bytes from the ps2_keyboard FIFO, folds E0/F0
// prefixes into make/break key events and presents them on a valid/ready port.
// Also tracks the held key, shift state, a wrapping press counter and a sticky
// overflow flag.
// Optional macro PS2_TYPEMATIC_FILTER_EN: when defined, typematic repeats of the
// held key are swallowed instead of producing press events.
module ps2_scan_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       fifo_data,
  input  logic             fifo_ready,
  input  logic             fifo_overflow,
  output logic             fifo_nextdata_n,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic [7:0]       cur_key,
  output logic             key_held,
  output logic             shift,
  output logic [CNT_W-1:0] press_count,
  output logic             ovf_sticky
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

  state_t           state;
  logic [7:0]       byte_r;
  logic             ext_pend;
  logic             brk_pend;
  logic [TMO_W-1:0] tmo_cnt;
  logic             cur_ext;
  logic             shift_l;
  logic             shift_r;

  logic is_e0;
  logic is_f0;
  logic is_ignored;
  logic key_match;
  logic is_repeat;
  logic rel_match;
  logic emit_ev;

  // Classify the latched byte against the prefix state and the held key.
  always_comb begin
    is_e0      = (byte_r == 8'hE0);
    is_f0      = (byte_r == 8'hF0);
    is_ignored = (byte_r == 8'h00) || (byte_r == 8'hAA) || (byte_r == 8'hFA) ||
                 (byte_r == 8'hFE) || (byte_r == 8'hFF) || (byte_r == 8'hE1);
    key_match  = key_held && (cur_key == byte_r) && (cur_ext == ext_pend);
    is_repeat  = !brk_pend && key_match;
    rel_match  = brk_pend && key_match;
`ifdef PS2_TYPEMATIC_FILTER_EN
    emit_ev    = !is_repeat;
`else
    emit_ev    = 1'b1;
`endif
  end

  assign shift = shift_l | shift_r;

  // Pop/decode sequencer, prefix timeout, key tracking and event handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      byte_r          <= 8'h00;
      fifo_nextdata_n <= 1'b1;
      ev_valid        <= 1'b0;
      ev_code         <= 8'h00;
      ev_ext          <= 1'b0;
      ev_break        <= 1'b0;
      cur_key         <= 8'h00;
      cur_ext         <= 1'b0;
      key_held        <= 1'b0;
      shift_l         <= 1'b0;
      shift_r         <= 1'b0;
      press_count     <= '0;
      ovf_sticky      <= 1'b0;
      ext_pend        <= 1'b0;
      brk_pend        <= 1'b0;
      tmo_cnt         <= '0;
    end else begin
      if (fifo_overflow)
        ovf_sticky <= 1'b1;

      if (ev_valid && ev_ready)
        ev_valid <= 1'b0;

      if (ext_pend || brk_pend) begin
        if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
          tmo_cnt  <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (fifo_ready && !ev_valid) begin
            byte_r          <= fifo_data;
            fifo_nextdata_n <= 1'b0;
            state           <= POP;
          end
        end
        POP: begin
          fifo_nextdata_n <= 1'b1;
          state           <= SETTLE;
          if (is_e0) begin
            ext_pend <= 1'b1;
            tmo_cnt  <= '0;
          end else if (is_f0) begin
            brk_pend <= 1'b1;
            tmo_cnt  <= '0;
          end else if (!is_ignored) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            tmo_cnt  <= '0;
            if (emit_ev) begin
              ev_valid <= 1'b1;
              ev_code  <= byte_r;
              ev_ext   <= ext_pend;
              ev_break <= brk_pend;
            end
            if (brk_pend) begin
              if (rel_match) begin
                key_held <= 1'b0;
                cur_key  <= 8'h00;
                cur_ext  <= 1'b0;
              end
              if (!ext_pend && byte_r == 8'h12) shift_l <= 1'b0;
              if (!ext_pend && byte_r == 8'h59) shift_r <= 1'b0;
            end else begin
              if (!is_repeat) begin
                cur_key     <= byte_r;
                cur_ext     <= ext_pend;
                key_held    <= 1'b1;
                press_count <= press_count + CNT_W'(1);
              end
              if (!ext_pend && byte_r == 8'h12) shift_l <= 1'b1;
              if (!ext_pend && byte_r == 8'h59) shift_r <= 1'b1;
            end
          end
        end
        SETTLE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// tb_ps2_scan_ctrl: directed scoreboard bench for ps2_scan_ctrl. A FIFO model
// feeds bytes; expected events are queued by the stimulus and compared by a
// separate monitor whenever an event is accepted.
module tb_ps2_scan_ctrl;

  localparam int TMO = 16;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    fifo_data;
  logic          fifo_ready;
  logic          fifo_overflow;
  logic          fifo_nextdata_n;
  logic          ev_valid;
  logic          ev_ready;
  logic [7:0]    ev_code;
  logic          ev_ext;
  logic          ev_break;
  logic [7:0]    cur_key;
  logic          key_held;
  logic          shift;
  logic [CW-1:0] press_count;
  logic          ovf_sticky;

  int errors = 0;
  int checks = 0;

  // FIFO model storage, written by stimulus and read through rd_ptr
  logic [7:0] fifo_mem [0:2047];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  // Scoreboard of expected {code, ext, break}
  logic [9:0] exp_mem [0:1023];
  int         exp_wr = 0;
  int         exp_rd = 0;

  logic low_prev = 1'b0;

  ps2_scan_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_data       (fifo_data),
    .fifo_ready      (fifo_ready),
    .fifo_overflow   (fifo_overflow),
    .fifo_nextdata_n (fifo_nextdata_n),
    .ev_valid        (ev_valid),
    .ev_ready        (ev_ready),
    .ev_code         (ev_code),
    .ev_ext          (ev_ext),
    .ev_break        (ev_break),
    .cur_key         (cur_key),
    .key_held        (key_held),
    .shift           (shift),
    .press_count     (press_count),
    .ovf_sticky      (ovf_sticky)
  );

  // Free-running clock
  always #5 clk = ~clk;

  assign fifo_ready = (rd_ptr != wr_ptr);
  assign fifo_data  = fifo_mem[rd_ptr[10:0]];

  // FIFO head advances on each edge where the pop strobe is low
  always @(posedge clk) begin
    if (!rst && !fifo_nextdata_n && fifo_ready)
      rd_ptr <= rd_ptr + 1;
  end

  // Monitor: compare each accepted event and police the pop strobe width
  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      checks++;
      if (exp_rd == exp_wr) begin
        errors++;
        $display("[TB] FAIL unexpected_event: got code=%h ext=%b brk=%b, expected none",
                 ev_code, ev_ext, ev_break);
      end else begin
        if ({ev_code, ev_ext, ev_break} !== exp_mem[exp_rd[9:0]]) begin
          errors++;
          $display("[TB] FAIL event_%0d: got %h/%b/%b, expected %h/%b/%b", exp_rd,
                   ev_code, ev_ext, ev_break, exp_mem[exp_rd[9:0]][9:2],
                   exp_mem[exp_rd[9:0]][1], exp_mem[exp_rd[9:0]][0]);
        end
        exp_rd++;
      end
    end
    if (!rst && !fifo_nextdata_n) begin
      checks++;
      if (low_prev) begin
        errors++;
        $display("[TB] FAIL pop_strobe_width: got low 2+ cycles, expected 1");
      end
    end
    low_prev = !fifo_nextdata_n;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [7:0] b);
    fifo_mem[wr_ptr[10:0]] = b;
    wr_ptr++;
  endtask

  task automatic expectEv(input logic [7:0] code, input logic ext, input logic brk);
    exp_mem[exp_wr[9:0]] = {code, ext, brk};
    exp_wr++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic waitDrain(input int max_cycles);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < max_cycles) begin
      @(negedge clk);
      n++;
      if (rd_ptr == wr_ptr && !ev_valid && exp_rd == exp_wr) quiet++;
      else quiet = 0;
    end
    checkOutput("drain_done", 32'(quiet >= 4), 32'd1);
  endtask

  task automatic applyReset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int start;
    rst = 1'b1;
    ev_ready = 1'b1;
    fifo_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_nextdata_n", 32'(fifo_nextdata_n), 32'd1);
    checkOutput("rst_ev_valid", 32'(ev_valid), 32'd0);
    checkOutput("rst_ev_code", 32'(ev_code), 32'd0);
    checkOutput("rst_cur_key", 32'(cur_key), 32'd0);
    checkOutput("rst_key_held", 32'(key_held), 32'd0);
    checkOutput("rst_shift", 32'(shift), 32'd0);
    checkOutput("rst_press_count", 32'(press_count), 32'd0);
    checkOutput("rst_ovf", 32'(ovf_sticky), 32'd0);

    // Simple make then break
    step();
    applyStimulus(8'h1C); expectEv(8'h1C, 1'b0, 1'b0);
    waitDrain(200);
    checkOutput("t1_cur_key_press", 32'(cur_key), 32'h1C);
    checkOutput("t1_key_held_press", 32'(key_held), 32'd1);
    checkOutput("t1_count_press", 32'(press_count), 32'd1);
    step();
    applyStimulus(8'hF0); applyStimulus(8'h1C); expectEv(8'h1C, 1'b0, 1'b1);
    waitDrain(200);
    checkOutput("t1_cur_key_rel", 32'(cur_key), 32'h00);
    checkOutput("t1_key_held_rel", 32'(key_held), 32'd0);
    checkOutput("t1_count_rel", 32'(press_count), 32'd1);

    // Extended make/break with ignored bytes interleaved
    applyReset();
    applyStimulus(8'hE0); applyStimulus(8'hFA); applyStimulus(8'h75);
    expectEv(8'h75, 1'b1, 1'b0);
    waitDrain(200);
    checkOutput("t2_cur_key", 32'(cur_key), 32'h75);
    checkOutput("t2_count", 32'(press_count), 32'd1);
    step();
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h00); applyStimulus(8'h75);
    expectEv(8'h75, 1'b1, 1'b1);
    waitDrain(200);
    checkOutput("t2_key_held_rel", 32'(key_held), 32'd0);

    // Typematic repeat
    applyReset();
    applyStimulus(8'h1C); applyStimulus(8'h1C); applyStimulus(8'h1C);
    expectEv(8'h1C, 1'b0, 1'b0);
`ifndef PS2_TYPEMATIC_FILTER_EN
    expectEv(8'h1C, 1'b0, 1'b0);
    expectEv(8'h1C, 1'b0, 1'b0);
`endif
    waitDrain(200);
    checkOutput("t3_count_repeat", 32'(press_count), 32'd1);
    checkOutput("t3_key_held", 32'(key_held), 32'd1);
    step();
    applyStimulus(8'hF0); applyStimulus(8'h1C); expectEv(8'h1C, 1'b0, 1'b1);
    waitDrain(200);

    // Backpressure: one pop only while the event is stalled
    applyReset();
    ev_ready = 1'b0;
    start = rd_ptr;
    applyStimulus(8'h1C); applyStimulus(8'h32); applyStimulus(8'h21);
    expectEv(8'h1C, 1'b0, 1'b0); expectEv(8'h32, 1'b0, 1'b0); expectEv(8'h21, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("t4_pops_stalled", 32'(rd_ptr - start), 32'd1);
    checkOutput("t4_valid_held", 32'(ev_valid), 32'd1);
    checkOutput("t4_code_held", 32'(ev_code), 32'h1C);
    step();
    ev_ready = 1'b1;
    waitDrain(200);
    checkOutput("t4_count", 32'(press_count), 32'd3);
    checkOutput("t4_cur_key", 32'(cur_key), 32'h21);

    // Prefix timeout
    applyReset();
    applyStimulus(8'hE0);
    waitDrain(200);
    repeat (20) @(posedge clk);
    #1 applyStimulus(8'h1C); expectEv(8'h1C, 1'b0, 1'b0);
    waitDrain(200);

    // Shift tracking
    applyReset();
    applyStimulus(8'h12); expectEv(8'h12, 1'b0, 1'b0);
    waitDrain(200);
    checkOutput("t6_shift_press", 32'(shift), 32'd1);
    step();
    applyStimulus(8'h1C); expectEv(8'h1C, 1'b0, 1'b0);
    waitDrain(200);
    checkOutput("t6_shift_other", 32'(shift), 32'd1);
    step();
    applyStimulus(8'hF0); applyStimulus(8'h12); expectEv(8'h12, 1'b0, 1'b1);
    waitDrain(200);
    checkOutput("t6_shift_rel", 32'(shift), 32'd0);
    checkOutput("t6_cur_key_kept", 32'(cur_key), 32'h1C);
    step();
    applyStimulus(8'hE0); applyStimulus(8'h59); expectEv(8'h59, 1'b1, 1'b0);
    waitDrain(200);
    checkOutput("t6_shift_ext", 32'(shift), 32'd0);

    // Press counter wrap
    applyReset();
    for (int i = 0; i < 255; i++) begin
      logic [7:0] c;
      c = i[0] ? 8'h32 : 8'h1C;
      applyStimulus(c); applyStimulus(8'hF0); applyStimulus(c);
      expectEv(c, 1'b0, 1'b0); expectEv(c, 1'b0, 1'b1);
    end
    waitDrain(10000);
    checkOutput("t7_count_ff", 32'(press_count), 32'hFF);
    step();
    applyStimulus(8'h1C); applyStimulus(8'hF0); applyStimulus(8'h1C);
    expectEv(8'h1C, 1'b0, 1'b0); expectEv(8'h1C, 1'b0, 1'b1);
    waitDrain(200);
    checkOutput("t7_count_wrap", 32'(press_count), 32'h00);

    // Sticky overflow
    step();
    fifo_overflow = 1'b1;
    step();
    fifo_overflow = 1'b0;
    @(negedge clk);
    checkOutput("t8_ovf_set", 32'(ovf_sticky), 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("t8_ovf_hold", 32'(ovf_sticky), 32'd1);
    applyReset();
    @(negedge clk);
    checkOutput("t8_ovf_clear", 32'(ovf_sticky), 32'd0);

    checkOutput("all_events_seen", 32'(exp_wr - exp_rd), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
